// File: rtl/aes256_ctr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : aes256_ctr_ctrl_if
// Desc   : Command, plaintext, FIFO-side and output buses of the CTR sequencer.
// Rev    : 1.0
// ============================================================================
interface aes256_ctr_ctrl_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   cmd_start;
    logic                   cmd_ready;
    logic [255:0]           cmd_key;
    logic [127:0]           cmd_iv;
    logic [COUNT_WIDTH-1:0] cmd_nblocks;
    logic                   s_valid;
    logic                   s_ready;
    logic [127:0]           s_block;
    logic                   aes_in_valid;
    logic                   aes_in_ready;
    logic [127:0]           aes_in_block;
    logic [127:0]           aes_ctr;
    logic [255:0]           aes_key;
    logic                   aes_out_valid;
    logic                   aes_out_ready;
    logic [127:0]           aes_out_block;
    logic                   aes_empty;
    logic                   m_valid;
    logic                   m_ready;
    logic [127:0]           m_block;
    logic                   m_last;
    logic                   busy;
    logic                   done;

    modport master (
        output cmd_start, cmd_key, cmd_iv, cmd_nblocks, s_valid, s_block,
               aes_in_ready, aes_out_valid, aes_out_block, aes_empty, m_ready,
        input  cmd_ready, s_ready, aes_in_valid, aes_in_block, aes_ctr, aes_key,
               aes_out_ready, m_valid, m_block, m_last, busy, done
    );

    modport slave (
        input  cmd_start, cmd_key, cmd_iv, cmd_nblocks, s_valid, s_block,
               aes_in_ready, aes_out_valid, aes_out_block, aes_empty, m_ready,
        output cmd_ready, s_ready, aes_in_valid, aes_in_block, aes_ctr, aes_key,
               aes_out_ready, m_valid, m_block, m_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/aes256_ctr_ctrl.sv
`default_nettype none
// ============================================================================
// Module : aes256_ctr_ctrl
// Desc   : CTR-mode job sequencer in front of the AES-256 pipeline FIFO.
// Rev    : 1.0
// ============================================================================
module aes256_ctr_ctrl #(
    parameter int CTR_WIDTH   = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    aes256_ctr_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [127:0]           c_LOW_MASK = (128'd1 << CTR_WIDTH) - 128'd1;
    localparam logic [COUNT_WIDTH-1:0] c_CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [255:0]           r_key;
    logic [127:0]           r_ctr;
    logic [COUNT_WIDTH-1:0] r_n;
    logic [COUNT_WIDTH-1:0] r_in_cnt;
    logic [COUNT_WIDTH-1:0] r_out_cnt;

    logic                   w_idle;
    logic                   w_run;
    logic                   w_out_act;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic [COUNT_WIDTH-1:0] w_n_m1;
    logic [127:0]           w_ctr_inc;
    logic [127:0]           w_ctr_next;

    assign w_idle    = (r_state == S_IDLE);
    assign w_run     = (r_state == S_RUN);
    assign w_out_act = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_in_hs   = w_run && bus.s_valid && bus.aes_in_ready;
    assign w_out_hs  = w_out_act && bus.aes_out_valid && bus.m_ready;
    assign w_n_m1    = r_n - c_CNT_ONE;

    // Only the low CTR_WIDTH bits advance; the carry out of that field is dropped.
    assign w_ctr_inc  = r_ctr + 128'd1;
    assign w_ctr_next = (r_ctr & ~c_LOW_MASK) | (w_ctr_inc & c_LOW_MASK);

    assign bus.cmd_ready     = w_idle;
    assign bus.busy          = !w_idle;
    assign bus.done          = (r_state == S_DONE);
    assign bus.aes_key       = r_key;
    assign bus.aes_ctr       = r_ctr;
    assign bus.aes_in_valid  = w_run && bus.s_valid;
    assign bus.s_ready       = w_run && bus.aes_in_ready;
    assign bus.aes_in_block  = w_run ? bus.s_block : 128'd0;
    assign bus.m_valid       = w_out_act && bus.aes_out_valid;
    assign bus.aes_out_ready = w_out_act && bus.m_ready;
    assign bus.m_block       = w_out_act ? bus.aes_out_block : 128'd0;
    assign bus.m_last        = bus.m_valid && (r_out_cnt == w_n_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_key     <= 256'd0;
            r_ctr     <= 128'd0;
            r_n       <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_start) begin
                        r_key     <= bus.cmd_key;
                        r_ctr     <= bus.cmd_iv;
                        r_n       <= bus.cmd_nblocks;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_state   <= (bus.cmd_nblocks == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_in_hs) begin
                        r_ctr    <= w_ctr_next;
                        r_in_cnt <= r_in_cnt + c_CNT_ONE;
                        if (r_in_cnt == w_n_m1) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((r_out_cnt == r_n) && bus.aes_empty) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            // Outputs may overtake the input side, so they count in RUN too.
            if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + c_CNT_ONE;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes256_ctr_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_aes256_ctr_ctrl
// Desc   : Randomized directed jobs against a CTR reference and a FIFO stand-in.
// Rev    : 1.0
// ============================================================================
module tb_aes256_ctr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    aes256_ctr_ctrl_if #(.COUNT_WIDTH(16)) bus();

    aes256_ctr_ctrl #(.CTR_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in pipeline: 30-cycle latency, 29 entries, toy cipher = data ^ ctr ^ folded key.
    logic [127:0] f_dat [0:63];
    int           f_rdy [0:63];
    int           f_head = 0;
    int           f_tail = 0;
    int           f_cnt  = 0;
    int           cyc_g  = 0;
    logic         f_push;
    logic         f_pop;

    assign bus.aes_in_ready  = (f_cnt < 29);
    assign bus.aes_empty     = (f_cnt == 0);
    assign bus.aes_out_valid = (f_cnt > 0) && (f_rdy[f_head] <= cyc_g);
    assign bus.aes_out_block = f_dat[f_head];
    assign f_push = bus.aes_in_valid && bus.aes_in_ready;
    assign f_pop  = bus.aes_out_valid && bus.aes_out_ready;

    always @(posedge clk) begin
        cyc_g <= cyc_g + 1;
        if (rst) begin
            f_head <= 0;
            f_tail <= 0;
            f_cnt  <= 0;
        end else begin
            if (f_push) begin
                f_dat[f_tail] <= bus.aes_in_block ^ bus.aes_ctr ^ bus.aes_key[255:128] ^ bus.aes_key[127:0];
                f_rdy[f_tail] <= cyc_g + 30;
                f_tail        <= (f_tail + 1) % 64;
            end
            if (f_pop) f_head <= (f_head + 1) % 64;
            f_cnt <= f_cnt + (f_push ? 1 : 0) - (f_pop ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ctr_ref(input logic [127:0] iv, input int k);
        logic [31:0] lo;
        lo = iv[31:0] + k;
        return {iv[127:32], lo};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_job(input logic [255:0] key, input logic [127:0] iv, input int n,
                           input int stall, input bit inject, input int abort_at);
        logic [127:0] pt [0:63];
        int nin = 0, nout = 0, ndone = 0, cyc = 0;
        bit fin = 0, post = 0, aborted = 0;
        for (int i = 0; i < n; i++) pt[i] = rnd128();
        @(negedge clk);
        bus.cmd_start = 1'b1; bus.cmd_key = key; bus.cmd_iv = iv; bus.cmd_nblocks = 16'(n);
        #1;
        check("accept_ready", bus.cmd_ready, 1'b1);
        @(negedge clk);
        while (!fin && cyc < 3000) begin
            if (abort_at > 0 && nin == abort_at) begin
                rst = 1'b1; bus.s_valid = 1'b0; bus.m_ready = 1'b0; bus.cmd_start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("abort_cmd_ready", bus.cmd_ready, 1'b1);
                check("abort_busy", bus.busy, 1'b0);
                check("abort_m_valid", bus.m_valid, 1'b0);
                check("abort_done", bus.done, 1'b0);
                check("abort_key", bus.aes_key, 256'd0);
                check("abort_ctr", bus.aes_ctr, 128'd0);
                @(negedge clk);
                #1;
                check("abort_no_done", bus.done, 1'b0);
                fin = 1; aborted = 1;
            end else begin
                bus.cmd_start = inject && (cyc == 3);
                if (bus.cmd_start) begin
                    bus.cmd_key = ~key; bus.cmd_iv = ~iv; bus.cmd_nblocks = 16'd7;
                end
                bus.s_valid = (nin < n) && (stall > 0 || $urandom_range(0, 3) != 0);
                bus.s_block = (nin < n) ? pt[nin] : rnd128();
                bus.m_ready = (cyc >= stall) && ($urandom_range(0, 3) != 0);
                #1;
                if (n == 0) check("zero_no_in_valid", bus.aes_in_valid, 1'b0);
                if (inject && cyc == 4) check("inject_key_kept", bus.aes_key, key);
                if (stall > 0 && cyc < stall && nin < n) check("stall_s_ready", bus.s_ready, nin < 29);
                if (stall > 0 && cyc == stall) check("stall_fill", 32'(nin), 32'd29);
                check("m_last", bus.m_last, bus.m_valid && (nout == n - 1));
                if (bus.aes_in_valid && bus.aes_in_ready) begin
                    check("in_block", bus.aes_in_block, pt[nin]);
                    check("in_ctr", bus.aes_ctr, ctr_ref(iv, nin));
                    check("in_key", bus.aes_key, key);
                    nin++;
                end
                if (bus.m_valid && bus.m_ready) begin
                    check("out_block", bus.m_block,
                          pt[nout] ^ ctr_ref(iv, nout) ^ key[255:128] ^ key[127:0]);
                    nout++;
                end
                if (post) begin
                    check("post_cmd_ready", bus.cmd_ready, 1'b1);
                    check("post_busy", bus.busy, 1'b0);
                    check("post_done", bus.done, 1'b0);
                    fin = 1;
                end else if (bus.done) begin
                    ndone++;
                    check("done_nin", 32'(nin), 32'(n));
                    check("done_nout", 32'(nout), 32'(n));
                    if (n == 0) check("zero_done_latency", 32'(cyc), 32'd0);
                    post = 1;
                end else begin
                    check("busy_in_job", bus.busy, 1'b1);
                end
                if (!fin) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        check("job_finished", fin, 1'b1);
        if (!aborted) check("done_count", 32'(ndone), 32'd1);
        bus.s_valid = 1'b0; bus.m_ready = 1'b0; bus.cmd_start = 1'b0;
    endtask

    initial begin
        logic [255:0] k;
        logic [127:0] v;
        bus.cmd_start = 1'b0; bus.cmd_key = '0; bus.cmd_iv = '0; bus.cmd_nblocks = '0;
        bus.s_valid = 1'b0; bus.s_block = '0; bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_last", bus.m_last, 1'b0);
        check("rst_s_ready", bus.s_ready, 1'b0);
        check("rst_in_valid", bus.aes_in_valid, 1'b0);
        check("rst_key", bus.aes_key, 256'd0);
        check("rst_ctr", bus.aes_ctr, 128'd0);

        k = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
        run_job(k, 128'h00112233445566778899AABBCCDDEEFF, 1, 0, 0, 0);
        k = {rnd128(), rnd128()};
        run_job(k, rnd128(), 6, 0, 0, 0);
        v = rnd128(); v[31:0] = 32'hFFFF_FFFE;
        run_job(k, v, 3, 0, 0, 0);
        run_job({rnd128(), rnd128()}, rnd128(), 0, 0, 0, 0);
        run_job({rnd128(), rnd128()}, rnd128(), 40, 100, 0, 0);
        run_job({rnd128(), rnd128()}, rnd128(), 8, 0, 1, 0);
        run_job({rnd128(), rnd128()}, rnd128(), 10, 0, 0, 5);
        run_job({rnd128(), rnd128()}, rnd128(), 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
